// File: rtl/control_pkg.sv
// Shared types and constants for the LEGv8-subset control sequencer:
// FSM states, opcodes, ALU/PC select codes and the datapath control-word layout.
package control_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [5:0]  OPC_B    = 6'b000101;

  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01001;
  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_ORR   = 5'b00100;
  localparam logic [4:0] FS_PASSB = 5'b10100;

  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_BRANCH = 2'b10;

  localparam int CW_PS_LSB     = 30;
  localparam int CW_DA_LSB     = 25;
  localparam int CW_SA_LSB     = 20;
  localparam int CW_SB_LSB     = 15;
  localparam int CW_FS_LSB     = 10;
  localparam int CW_REGW_BIT   = 9;
  localparam int CW_RAMW_BIT   = 8;
  localparam int CW_EN_MEM_BIT = 7;
  localparam int CW_EN_ALU_BIT = 6;
  localparam int CW_EN_B_BIT   = 5;
  localparam int CW_EN_PC_BIT  = 4;
  localparam int CW_SELB_BIT   = 3;
  localparam int CW_PCSEL_BIT  = 2;
  localparam int CW_SL_BIT     = 1;
  localparam int CW_RSVD_BIT   = 0;

  // Each field spans from its own LSB up to the LSB of the field above it.
  typedef struct packed {
    logic [31-CW_PS_LSB:0]                    ps;
    logic [CW_PS_LSB-CW_DA_LSB-1:0]           da;
    logic [CW_DA_LSB-CW_SA_LSB-1:0]           sa;
    logic [CW_SA_LSB-CW_SB_LSB-1:0]           sb;
    logic [CW_SB_LSB-CW_FS_LSB-1:0]           fs;
    logic [CW_FS_LSB-CW_REGW_BIT-1:0]         reg_w;
    logic [CW_REGW_BIT-CW_RAMW_BIT-1:0]       ram_w;
    logic [CW_RAMW_BIT-CW_EN_MEM_BIT-1:0]     en_mem;
    logic [CW_EN_MEM_BIT-CW_EN_ALU_BIT-1:0]   en_alu;
    logic [CW_EN_ALU_BIT-CW_EN_B_BIT-1:0]     en_b;
    logic [CW_EN_B_BIT-CW_EN_PC_BIT-1:0]      en_pc;
    logic [CW_EN_PC_BIT-CW_SELB_BIT-1:0]      sel_b;
    logic [CW_SELB_BIT-CW_PCSEL_BIT-1:0]      pc_sel;
    logic [CW_PCSEL_BIT-CW_SL_BIT-1:0]        sl;
    logic [CW_SL_BIT-CW_RSVD_BIT-1:0]         rsvd;
  } ctrl_word_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDI, OP_SUBI,
    OP_LDUR, OP_STUR, OP_B, OP_CBZ, OP_ILL
  } op_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_U12, IMM_S9, IMM_S19, IMM_S26
  } imm_sel_e;

  // Longest opcode wins: 11-bit codes, then 10, 8 and 6.
  function automatic op_e decode_op(input logic [10:0] opc);
    op_e r;
    r = OP_ILL;
    if      (opc == OPC_ADD)       r = OP_ADD;
    else if (opc == OPC_SUB)       r = OP_SUB;
    else if (opc == OPC_AND)       r = OP_AND;
    else if (opc == OPC_ORR)       r = OP_ORR;
    else if (opc == OPC_LDUR)      r = OP_LDUR;
    else if (opc == OPC_STUR)      r = OP_STUR;
    else if (opc[10:1] == OPC_ADDI) r = OP_ADDI;
    else if (opc[10:1] == OPC_SUBI) r = OP_SUBI;
    else if (opc[10:3] == OPC_CBZ)  r = OP_CBZ;
    else if (opc[10:5] == OPC_B)    r = OP_B;
    return r;
  endfunction

endpackage

// File: rtl/control_sequencer_imm_extend.sv
// Immediate extraction: picks the instruction's immediate field by format
// and zero- or sign-extends it to the 64-bit datapath constant.
module imm_extend
  import control_pkg::*;
(
  input  logic [25:0] imm_bits,
  input  logic [2:0]  sel,
  output logic [63:0] k
);

  always_comb begin
    k = '0;
    case (sel)
      IMM_U12: k = {52'b0, imm_bits[21:10]};
      IMM_S9:  k = {{55{imm_bits[20]}}, imm_bits[20:12]};
      IMM_S19: k = {{45{imm_bits[23]}}, imm_bits[23:5]};
      IMM_S26: k = {{38{imm_bits[25]}}, imm_bits[25:0]};
      default: k = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle LEGv8-subset control unit: latches the instruction in FETCH and
// emits one datapath control word (plus constant k) per state.
module control_sequencer
  import control_pkg::*;
#(
  parameter state_e RESET_STATE = S_FETCH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [3:0]  status,
  output logic [31:0] controlWord,
  output logic [63:0] k,
  output logic [1:0]  state,
  output logic        halted
);

  state_e     state_q, state_d;
  logic [31:0] ir_q, ir_d;
  ctrl_word_t cw;
  imm_sel_e   imm_sel;
  op_e        op;
  logic [4:0] rd, rn, rm;
  logic       unused_status;

  assign rd = ir_q[4:0];
  assign rn = ir_q[9:5];
  assign rm = ir_q[20:16];
  assign op = decode_op(ir_q[31:21]);
  assign unused_status = ^status[3:1];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= RESET_STATE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    cw      = '0;
    imm_sel = IMM_NONE;
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = instruction;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
            cw.ps = PS_INC; cw.da = rd; cw.sa = rn; cw.sb = rm;
            cw.en_b = 1'b1; cw.en_alu = 1'b1; cw.reg_w = 1'b1;
            case (op)
              OP_SUB:  cw.fs = FS_SUB;
              OP_AND:  cw.fs = FS_AND;
              OP_ORR:  cw.fs = FS_ORR;
              default: cw.fs = FS_ADD;
            endcase
          end
          OP_ADDI, OP_SUBI: begin
            imm_sel = IMM_U12;
            cw.ps = PS_INC; cw.da = rd; cw.sa = rn; cw.sel_b = 1'b1;
            cw.en_alu = 1'b1; cw.reg_w = 1'b1;
            cw.fs = (op == OP_SUBI) ? FS_SUB : FS_ADD;
          end
          OP_LDUR: begin
            // Address phase only; the register write happens in S_MEM.
            imm_sel = IMM_S9;
            cw.ps = PS_HOLD; cw.sa = rn; cw.sel_b = 1'b1; cw.fs = FS_ADD;
            cw.en_mem = 1'b1;
            state_d = S_MEM;
          end
          OP_STUR: begin
            imm_sel = IMM_S9;
            cw.ps = PS_INC; cw.sa = rn; cw.sb = rd; cw.fs = FS_ADD;
            cw.sel_b = 1'b1; cw.ram_w = 1'b1;
          end
          OP_B: begin
            imm_sel = IMM_S26;
            cw.ps = PS_BRANCH;
          end
          OP_CBZ: begin
            imm_sel = IMM_S19;
            cw.sb = rd; cw.en_b = 1'b1; cw.fs = FS_PASSB;
            cw.ps = status[0] ? PS_BRANCH : PS_INC;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        imm_sel = IMM_S9;
        cw.ps = PS_INC; cw.sa = rn; cw.sel_b = 1'b1; cw.fs = FS_ADD;
        cw.en_mem = 1'b1; cw.reg_w = 1'b1; cw.da = rd;
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  imm_extend u_imm_extend (
    .imm_bits (ir_q[25:0]),
    .sel      (imm_sel),
    .k        (k)
  );

  // Reset gates the control word so nothing is written in the reset cycle.
  assign controlWord = reset ? cw : '0;
  assign state       = state_q;
  assign halted      = (state_q == S_HALT);

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control unit that fetches 32-bit instructions from the instruction ROM, decodes a LEGv8 subset, and drives the datapath's 32-bit control word and 64-bit constant `k` one state per clock. It sits between the ROM output and the datapath control inputs. It closes the loop opposite the datapath: the datapath consumes control words, and this block produces them. It also consumes datapath status for conditional branches.

## Interface
Parameters:
- `RESET_STATE`, `S_FETCH`: state entered on reset.

Ports:
- `clock` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-low (sampled on `clock` rising edge; 0 = reset).
- `instruction` input 32: ROM data at current PC.
- `status` input 4: {V,C,N,Z} from the ALU; combinational, current cycle.
- `controlWord` output 32: control word to the datapath.
- `k` output 64: sign- or zero-extended immediate.
- `state` output 2: current FSM state, for debug.
- `halted` output 1: 1 while in S_HALT.

## Operation
- Control word bit layout (the datapath contract):
  - [31:30] PS, [29:25] DA, [24:20] SA, [19:15] SB, [14:10] FS
  - [9] regW, [8] ramW, [7] EN_MEM, [6] EN_ALU, [5] EN_B, [4] EN_PC
  - [3] selB (1 = `k` feeds ALU B), [2] PCsel (always 0), [1] SL (load status), [0] reserved = 0.
- PS codes: 00 hold, 01 PC+4, 10 PC+4+(k<<2).
- FS codes: ADD=01000, SUB=01001, AND=00000, ORR=00100, PASSB=10100.
- States: S_FETCH=0, S_EXEC=1, S_MEM=2, S_HALT=3.
- S_FETCH:
  - IR <= `instruction`.
  - controlWord = 0 (NOP, PS=00).
  - Next state: S_EXEC.
- S_EXEC: decode IR.
  - R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000:
    - DA=Rd, SA=Rn, SB=Rm, EN_B=1, EN_ALU=1, regW=1, PS=01.
    - Next: S_FETCH.
  - I-type ADDI 1001000100, SUBI 1101000100:
    - k = zero-extended imm12, selB=1, DA=Rd, SA=Rn, EN_ALU=1, regW=1, PS=01.
    - Next: S_FETCH.
  - LDUR 11111000010:
    - k = sign-extended imm9, SA=Rn, selB=1, FS=ADD, EN_MEM=1, regW=0, PS=00.
    - Next: S_MEM.
  - STUR 11111000000:
    - k = sign-extended imm9, SA=Rn, SB=Rt, FS=ADD, selB=1, ramW=1, PS=01.
    - Next: S_FETCH.
  - B 000101:
    - k = sign-extended imm26, PS=10, no writes.
    - Next: S_FETCH.
  - CBZ 10110100:
    - SB=Rt, EN_B=1, FS=PASSB, k = sign-extended imm19.
    - PS = status[0] ? 10 : 01 (combinational on `status`).
    - Next: S_FETCH.
  - Any other opcode: controlWord=0. Next: S_HALT.
- S_MEM (LDUR only):
  - Same address fields as in S_EXEC, plus EN_MEM=1, regW=1, DA=Rt, PS=01.
  - Next: S_FETCH.
- S_HALT: controlWord=0, `halted`=1. Exits only via reset.
- Decode priority: longest opcode match first (11-bit, then 10, 8, 6).
- Register field 31 is passed through unchanged; the register file treats it as XZR.

## Timing
- Reset: `reset`=0 at an edge gives state=S_FETCH, IR=0, `k`=0, `halted`=0.
- While `reset`=0, controlWord is forced to 0 combinationally, so no writes occur in the reset cycle.
- Reset mid-instruction (any state) aborts the instruction; the PC is not advanced by this block.
- CPI:
  - ALU, STUR, B, CBZ: 2 cycles.
  - LDUR: 3 cycles.
- The PC advances only on the last cycle of each instruction. The `instruction` input is sampled only in S_FETCH.
- `k` and controlWord are combinational from IR and state. IR is stable for the whole instruction.
- The `status` to PS path is combinational. It is valid because the ALU settles within the S_EXEC cycle.

## Structure
- Package `control_pkg`:
  - state enum
  - opcode constants
  - FS codes and PS codes
  - control-word bit-position constants
  - a packed struct for the control word
- One sub-module `imm_extend`: selects the immediate format and extends it to 64 bits.

## Test plan
- Reset, then `instruction`=0x8B020023 (ADD X3,X1,X2):
  - S_FETCH gives controlWord=0.
  - S_EXEC gives DA=3, SA=1, SB=2, FS=01000, regW=1, EN_B=1, EN_ALU=1, PS=01.
  - Returns to S_FETCH.
- 0x910017E1 (ADDI X1,XZR,#5): `k`=5, selB=1, DA=1, SA=31, PS=01.
- 0xF8408022 (LDUR X2,[X1,#8]):
  - `k`=8.
  - S_EXEC: regW=0, PS=00.
  - S_MEM: regW=1, DA=2, EN_MEM=1, PS=01.
  - Total 3 cycles.
- 0x17FFFFFE (B #-2): `k`=0xFFFF_FFFF_FFFF_FFFE, PS=10, regW=ramW=0.
- CBZ with status=0001 gives PS=10. The same instruction with status=0000 gives PS=01.
- Illegal-opcode and reset checks:
  - 0x00000000 leads to S_HALT with `halted`=1 and controlWord=0 held for 5 cycles.
  - Pulsing `reset`=0 for one edge returns to S_FETCH.
  - Asserting `reset`=0 during LDUR S_MEM gives regW=0 that cycle.
